// File: rtl/aurora_hls_pkg.sv
// Shared definitions for the Aurora-HLS link sequencer: status bit map,
// state encoding and small helper functions.
package aurora_hls_pkg;

    localparam int STATUS_W = 13;

    localparam logic [STATUS_W-1:0] GT_POWERGOOD_MASK    = 13'h000F;
    localparam logic [STATUS_W-1:0] LANE_UP_MASK         = 13'h00F0;
    localparam logic [STATUS_W-1:0] GT_PLL_LOCK_MASK     = 13'h0100;
    localparam logic [STATUS_W-1:0] MMCM_NOT_LOCKED_MASK = 13'h0200;
    localparam logic [STATUS_W-1:0] HARD_ERR_MASK        = 13'h0400;
    localparam logic [STATUS_W-1:0] SOFT_ERR_MASK        = 13'h0800;
    localparam logic [STATUS_W-1:0] CHANNEL_UP_MASK      = 13'h1000;

    // Bits that take part in link_ok, and the value they must hold.
    localparam logic [STATUS_W-1:0] LINK_OK_MASK  = CHANNEL_UP_MASK | LANE_UP_MASK |
                                                    GT_PLL_LOCK_MASK | MMCM_NOT_LOCKED_MASK |
                                                    HARD_ERR_MASK;
    localparam logic [STATUS_W-1:0] LINK_OK_VALUE = CHANNEL_UP_MASK | LANE_UP_MASK |
                                                    GT_PLL_LOCK_MASK;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEAD    = 3'd1,
        ST_PMA     = 3'd2,
        ST_TAIL    = 3'd3,
        ST_WAIT_UP = 3'd4,
        ST_STABLE  = 3'd5,
        ST_READY   = 3'd6
    } state_e;

    function automatic logic link_ok_f(input logic [STATUS_W-1:0] status);
        return (status & LINK_OK_MASK) == LINK_OK_VALUE;
    endfunction

    function automatic logic reset_pb_f(input state_e s);
        case (s)
            ST_WAIT_UP, ST_STABLE, ST_READY: return 1'b0;
            default:                         return 1'b1;
        endcase
    endfunction

    function automatic logic pma_init_f(input state_e s);
        case (s)
            ST_IDLE, ST_PMA: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc_f(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aurora_hls_link_sequencer_phase_timer.sv
// Loadable down-counter that stops at zero; done is high while the value is zero.
module aurora_hls_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: load wins, otherwise count down and hold at zero.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (value_q != {WIDTH{1'b0}}) begin
            value_d = value_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            value_d = value_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= {WIDTH{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign done  = (value_q == {WIDTH{1'b0}});

endmodule

// File: rtl/aurora_hls_link_sequencer.sv
// Bring-up / recovery sequencer for one Aurora 64B/66B core: drives reset_pb and
// pma_init, qualifies link status into link_ready and gates user TX until ready.
module aurora_hls_link_sequencer
    import aurora_hls_pkg::*;
#(
    parameter int RESET_PB_LEAD = 128,
    parameter int PMA_HOLD      = 1024,
    parameter int RESET_PB_TAIL = 128,
    parameter int LINK_TIMEOUT  = 16777216,
    parameter int STABLE_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [STATUS_W-1:0] aurora_status,
    output logic                reset_pb,
    output logic                pma_init,
    output logic                link_ready,
    output logic [2:0]          state,
    input  logic                s_tx_tvalid,
    output logic                s_tx_tready,
    output logic                m_tx_tvalid,
    input  logic                m_tx_tready,
    output logic [31:0]         reinit_count,
    output logic [31:0]         timeout_count
);

    localparam int MAX_PARAM = max_f(max_f(max_f(RESET_PB_LEAD, PMA_HOLD),
                                           max_f(RESET_PB_TAIL, LINK_TIMEOUT)),
                                     STABLE_CYCLES);
    localparam int TIMER_W   = $clog2(MAX_PARAM) + 1;

    // Timers hold at zero, so loading N-1 gives exactly N cycles before done.
    localparam logic [TIMER_W-1:0] LEAD_LOAD   = TIMER_W'(RESET_PB_LEAD - 1);
    localparam logic [TIMER_W-1:0] PMA_LOAD    = TIMER_W'(PMA_HOLD - 1);
    localparam logic [TIMER_W-1:0] TAIL_LOAD   = TIMER_W'(RESET_PB_TAIL - 1);
    localparam logic [TIMER_W-1:0] STABLE_LOAD = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TMO_LOAD    = TIMER_W'(LINK_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                reset_pb_q, pma_init_q, link_ready_q;
    logic [31:0]         reinit_count_q, reinit_count_d;
    logic [31:0]         timeout_count_q, timeout_count_d;

    logic                link_ok_s;
    logic                phase_load_s;
    logic [TIMER_W-1:0]  phase_load_value_s;
    logic                phase_done_s;
    logic [TIMER_W-1:0]  phase_value_unused;
    logic                tmo_load_s;
    logic                tmo_done_s;
    logic [TIMER_W-1:0]  tmo_value_unused;

    assign link_ok_s = link_ok_f(aurora_status);

    // Shared by the reset phases and the stable-window count.
    aurora_hls_phase_timer #(.WIDTH(TIMER_W)) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (phase_load_s),
        .load_value (phase_load_value_s),
        .value      (phase_value_unused),
        .done       (phase_done_s)
    );

    aurora_hls_phase_timer #(.WIDTH(TIMER_W)) u_timeout_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmo_load_s),
        .load_value (TMO_LOAD),
        .value      (tmo_value_unused),
        .done       (tmo_done_s)
    );

    // Next-state, timer loads and counter updates; enable=0 overrides everything.
    always_comb begin
        state_d            = state_q;
        phase_load_s       = 1'b0;
        phase_load_value_s = {TIMER_W{1'b0}};
        tmo_load_s         = 1'b0;
        reinit_count_d     = reinit_count_q;
        timeout_count_d    = timeout_count_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d            = ST_LEAD;
                    phase_load_s       = 1'b1;
                    phase_load_value_s = LEAD_LOAD;
                end
                ST_LEAD: begin
                    if (phase_done_s) begin
                        state_d            = ST_PMA;
                        phase_load_s       = 1'b1;
                        phase_load_value_s = PMA_LOAD;
                    end else begin
                        state_d = ST_LEAD;
                    end
                end
                ST_PMA: begin
                    if (phase_done_s) begin
                        state_d            = ST_TAIL;
                        phase_load_s       = 1'b1;
                        phase_load_value_s = TAIL_LOAD;
                    end else begin
                        state_d = ST_PMA;
                    end
                end
                ST_TAIL: begin
                    if (phase_done_s) begin
                        state_d    = ST_WAIT_UP;
                        tmo_load_s = 1'b1;
                    end else begin
                        state_d = ST_TAIL;
                    end
                end
                ST_WAIT_UP: begin
                    if (tmo_done_s) begin
                        state_d            = ST_LEAD;
                        phase_load_s       = 1'b1;
                        phase_load_value_s = LEAD_LOAD;
                        timeout_count_d    = sat_inc_f(timeout_count_q);
                    end else if (link_ok_s) begin
                        state_d            = ST_STABLE;
                        phase_load_s       = 1'b1;
                        phase_load_value_s = STABLE_LOAD;
                    end else begin
                        state_d = ST_WAIT_UP;
                    end
                end
                ST_STABLE: begin
                    if (tmo_done_s) begin
                        state_d            = ST_LEAD;
                        phase_load_s       = 1'b1;
                        phase_load_value_s = LEAD_LOAD;
                        timeout_count_d    = sat_inc_f(timeout_count_q);
                    end else if (!link_ok_s) begin
                        state_d = ST_WAIT_UP;
                    end else if (phase_done_s) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_STABLE;
                    end
                end
                ST_READY: begin
                    if (!link_ok_s) begin
                        state_d            = ST_LEAD;
                        phase_load_s       = 1'b1;
                        phase_load_value_s = LEAD_LOAD;
                        reinit_count_d     = sat_inc_f(reinit_count_q);
                    end else begin
                        state_d = ST_READY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, core controls and counters; controls follow the next state so they
    // change on the same edge as the transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            reset_pb_q      <= 1'b1;
            pma_init_q      <= 1'b1;
            link_ready_q    <= 1'b0;
            reinit_count_q  <= 32'd0;
            timeout_count_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            reset_pb_q      <= reset_pb_f(state_d);
            pma_init_q      <= pma_init_f(state_d);
            link_ready_q    <= (state_d == ST_READY);
            reinit_count_q  <= reinit_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign state         = state_q;
    assign reset_pb      = reset_pb_q;
    assign pma_init      = pma_init_q;
    assign link_ready    = link_ready_q;
    assign reinit_count  = reinit_count_q;
    assign timeout_count = timeout_count_q;

    // A pending beat is withdrawn when the link drops; the core is being reset anyway.
    assign m_tx_tvalid = s_tx_tvalid & link_ready_q;
    assign s_tx_tready = m_tx_tready & link_ready_q;

endmodule
